// File: rtl/des_key_schedule_seq.sv
// Sequential DES-family key schedule: PC-1 on key load, then one PC-2 subkey
// per accepted handshake, in forward (encrypt) or reverse (decrypt) order.
module des_key_schedule_seq #(
    parameter int unsigned KEY_W  = 64,
    parameter int unsigned ROUNDS = 16
) (
    input  logic                        Clk,
    input  logic                        Reset,
    input  logic [KEY_W-1:0]            Key_in,
    input  logic                        Key_valid,
    input  logic                        Decrypt,
    output logic                        Key_ready,
    output logic [48*(KEY_W/64)-1:0]    Subkey,
    output logic                        Subkey_valid,
    input  logic                        Subkey_ready,
    output logic [4:0]                  Round_idx,
    output logic                        Last
);

    localparam int unsigned LANES = KEY_W / 64;
    localparam int unsigned CW    = 28 * LANES;
    localparam int unsigned SKW   = 48 * LANES;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    localparam int unsigned PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int unsigned PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    // Per-round left-shift amount of the standard schedule (rounds 1..16).
    function automatic logic [5:0] shift_of(input logic [4:0] r);
        return (r == 5'd1 || r == 5'd2 || r == 5'd9 || r == 5'd16) ? 6'd1 : 6'd2;
    endfunction

    // Total rotation after ROUNDS rounds, i.e. the decrypt starting offset.
    function automatic int unsigned tot_calc();
        int unsigned s;
        s = 0;
        for (int unsigned r = 1; r <= ROUNDS; r++) begin
            s += (r == 1 || r == 2 || r == 9 || r == 16) ? 1 : 2;
        end
        return s;
    endfunction

    localparam int unsigned TOT = tot_calc();

    // DES bit n of a lane is k[64-n]; output bit 1 is the MSB.
    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] o;
        o = '0;
        for (int i = 0; i < 56; i++) begin
            o[55-i] = k[64-PC1_T[i]];
        end
        return o;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] o;
        o = '0;
        for (int i = 0; i < 48; i++) begin
            o[47-i] = cd[56-PC2_T[i]];
        end
        return o;
    endfunction

    // PC-1 on every lane, packed as {C, D} with lane 1 in the upper half of each.
    function automatic logic [2*CW-1:0] pc1_all(input logic [KEY_W-1:0] k);
        logic [CW-1:0] c;
        logic [CW-1:0] d;
        logic [55:0]   cd;
        c = '0;
        d = '0;
        for (int l = 0; l < int'(LANES); l++) begin
            cd             = pc1(k[64*l +: 64]);
            c[28*l +: 28]  = cd[55:28];
            d[28*l +: 28]  = cd[27:0];
        end
        return {c, d};
    endfunction

    function automatic logic [SKW-1:0] pc2_all(input logic [CW-1:0] c, input logic [CW-1:0] d);
        logic [SKW-1:0] o;
        o = '0;
        for (int l = 0; l < int'(LANES); l++) begin
            o[48*l +: 48] = pc2({c[28*l +: 28], d[28*l +: 28]});
        end
        return o;
    endfunction

    // Rotations act across the full register, so bits move between lanes.
    function automatic logic [CW-1:0] rotl(input logic [CW-1:0] x, input logic [5:0] n);
        logic [2*CW-1:0] t;
        t = {x, x} << n;
        return t[2*CW-1:CW];
    endfunction

    function automatic logic [CW-1:0] rotr(input logic [CW-1:0] x, input logic [5:0] n);
        logic [2*CW-1:0] t;
        t = {x, x} >> n;
        return t[CW-1:0];
    endfunction

    logic [1:0]       state_q, state_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic             dec_q, dec_d;
    logic [CW-1:0]    c_q, c_d, d_q, d_d;
    logic [SKW-1:0]   subkey_q, subkey_d;
    logic             valid_q, valid_d;
    logic [4:0]       round_q, round_d;
    logic             last_q, last_d;
    logic             key_ready_q, key_ready_d;

    logic [2*CW-1:0]  pc1_c;
    logic [CW-1:0]    adv_c_c, adv_d_c;
    logic [4:0]       adv_round_c;

    // Next-round C/D and round number for the stored direction.
    always_comb begin
        pc1_c       = pc1_all(key_q);
        adv_c_c     = c_q;
        adv_d_c     = d_q;
        adv_round_c = round_q;
        if (dec_q) begin
            adv_c_c     = rotr(c_q, shift_of(round_q));
            adv_d_c     = rotr(d_q, shift_of(round_q));
            adv_round_c = round_q - 5'd1;
        end else begin
            adv_c_c     = rotl(c_q, shift_of(round_q + 5'd1));
            adv_d_c     = rotl(d_q, shift_of(round_q + 5'd1));
            adv_round_c = round_q + 5'd1;
        end
    end

    // Next-state and output logic for IDLE / LOAD / RUN.
    always_comb begin
        state_d     = state_q;
        key_d       = key_q;
        dec_d       = dec_q;
        c_d         = c_q;
        d_d         = d_q;
        subkey_d    = subkey_q;
        valid_d     = valid_q;
        round_d     = round_q;
        last_d      = last_q;
        key_ready_d = key_ready_q;
        case (state_q)
            ST_IDLE: begin
                if (Key_valid && key_ready_q) begin
                    key_d       = Key_in;
                    dec_d       = Decrypt;
                    key_ready_d = 1'b0;
                    state_d     = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (dec_q) begin
                    c_d = rotl(pc1_c[2*CW-1:CW], 6'(TOT));
                    d_d = rotl(pc1_c[CW-1:0],    6'(TOT));
                end else begin
                    c_d = rotl(pc1_c[2*CW-1:CW], 6'd1);
                    d_d = rotl(pc1_c[CW-1:0],    6'd1);
                end
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!valid_q) begin
                    subkey_d = pc2_all(c_q, d_q);
                    valid_d  = 1'b1;
                    round_d  = dec_q ? 5'(ROUNDS) : 5'd1;
                    last_d   = (ROUNDS == 1);
                end else if (Subkey_ready) begin
                    if (last_q) begin
                        valid_d     = 1'b0;
                        last_d      = 1'b0;
                        key_ready_d = 1'b1;
                        state_d     = ST_IDLE;
                    end else begin
                        c_d      = adv_c_c;
                        d_d      = adv_d_c;
                        subkey_d = pc2_all(adv_c_c, adv_d_c);
                        round_d  = adv_round_c;
                        last_d   = dec_q ? (adv_round_c == 5'd1) : (adv_round_c == 5'(ROUNDS));
                    end
                end
            end
            default: begin
                state_d     = ST_IDLE;
                valid_d     = 1'b0;
                last_d      = 1'b0;
                key_ready_d = 1'b1;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q     <= ST_IDLE;
            key_q       <= '0;
            dec_q       <= 1'b0;
            c_q         <= '0;
            d_q         <= '0;
            subkey_q    <= '0;
            valid_q     <= 1'b0;
            round_q     <= '0;
            last_q      <= 1'b0;
            key_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            dec_q       <= dec_d;
            c_q         <= c_d;
            d_q         <= d_d;
            subkey_q    <= subkey_d;
            valid_q     <= valid_d;
            round_q     <= round_d;
            last_q      <= last_d;
            key_ready_q <= key_ready_d;
        end
    end

    assign Key_ready    = key_ready_q;
    assign Subkey       = subkey_q;
    assign Subkey_valid = valid_q;
    assign Round_idx    = round_q;
    assign Last         = last_q;

endmodule

// File: tb/tb_des_key_schedule_seq.sv
// Bench for des_key_schedule_seq: three configurations share one stimulus
// stream and are compared every cycle against a table-driven DES schedule model.
module tb_des_key_schedule_seq;

    localparam int NI = 3;
    int lanes_t  [NI] = '{1, 2, 1};
    int rounds_t [NI] = '{16, 11, 1};

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic         Reset, Key_valid, Decrypt, Subkey_ready;
    logic [63:0]  key64;
    logic [127:0] key128;

    logic        kr0, kr1, kr2, v0, v1, v2, l0, l1, l2;
    logic [47:0] sk0, sk2;
    logic [95:0] sk1;
    logic [4:0]  ri0, ri1, ri2;

    des_key_schedule_seq #(.KEY_W(64), .ROUNDS(16)) dut0 (
        .Clk(Clk), .Reset(Reset), .Key_in(key64), .Key_valid(Key_valid), .Decrypt(Decrypt),
        .Key_ready(kr0), .Subkey(sk0), .Subkey_valid(v0), .Subkey_ready(Subkey_ready),
        .Round_idx(ri0), .Last(l0));
    des_key_schedule_seq #(.KEY_W(128), .ROUNDS(11)) dut1 (
        .Clk(Clk), .Reset(Reset), .Key_in(key128), .Key_valid(Key_valid), .Decrypt(Decrypt),
        .Key_ready(kr1), .Subkey(sk1), .Subkey_valid(v1), .Subkey_ready(Subkey_ready),
        .Round_idx(ri1), .Last(l1));
    des_key_schedule_seq #(.KEY_W(64), .ROUNDS(1)) dut2 (
        .Clk(Clk), .Reset(Reset), .Key_in(key64), .Key_valid(Key_valid), .Decrypt(Decrypt),
        .Key_ready(kr2), .Subkey(sk2), .Subkey_valid(v2), .Subkey_ready(Subkey_ready),
        .Round_idx(ri2), .Last(l2));

    int PC1_T [56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,60,52,44,36,
                       63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,29,21,13,5,28,20,12,4};
    int PC2_T [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                       41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
    int S_T   [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

    localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
    localparam logic [47:0] K1    = 48'h1B02EFFC7072;
    localparam logic [47:0] K2    = 48'h79AED9DBC9E5;
    localparam logic [47:0] K16   = 48'hCB3D8B0E17F5;

    int n_checks = 0;
    int n_pass   = 0;
    bit run_chk  = 1'b0;

    // Model state per instance.
    logic [95:0] seq  [NI][16];
    int          sidx [NI][16];
    int          ph   [NI];
    int          pos  [NI];
    bit          e_ready [NI], e_valid [NI], e_last [NI], chk_data [NI];
    logic [95:0] e_sub [NI];
    int          e_idx [NI];

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [55:0] m_pc1(input logic [63:0] k);
        logic [55:0] o;
        o = '0;
        for (int i = 0; i < 56; i++) o[55-i] = k[64-PC1_T[i]];
        return o;
    endfunction

    function automatic logic [47:0] m_pc2(input logic [55:0] cd);
        logic [47:0] o;
        o = '0;
        for (int i = 0; i < 48; i++) o[47-i] = cd[56-PC2_T[i]];
        return o;
    endfunction

    function automatic logic [55:0] m_rotl(input logic [55:0] x, input int n, input int cw);
        logic [55:0] r;
        r = '0;
        for (int j = 0; j < cw; j++) r[(j + n) % cw] = x[j];
        return r;
    endfunction

    // Full subkey list for a key: round r uses C0/D0 rotated by the running shift total.
    task automatic build(input int i, input logic [127:0] key, input bit dec);
        logic [55:0] c0, d0, cr, dr, cd;
        logic [95:0] sk;
        int lanes, rounds, cw, tot, p;
        lanes  = lanes_t[i];
        rounds = rounds_t[i];
        cw     = 28 * lanes;
        c0 = '0;
        d0 = '0;
        for (int l = 0; l < lanes; l++) begin
            cd = m_pc1(key[64*l +: 64]);
            c0[28*l +: 28] = cd[55:28];
            d0[28*l +: 28] = cd[27:0];
        end
        tot = 0;
        for (int r = 1; r <= rounds; r++) begin
            tot += S_T[r-1];
            cr = m_rotl(c0, tot, cw);
            dr = m_rotl(d0, tot, cw);
            sk = '0;
            for (int l = 0; l < lanes; l++) sk[48*l +: 48] = m_pc2({cr[28*l +: 28], dr[28*l +: 28]});
            p = dec ? rounds - r : r - 1;
            seq[i][p]  = sk;
            sidx[i][p] = r;
        end
    endtask

    task automatic present(input int i);
        e_sub[i]  = seq[i][pos[i]];
        e_idx[i]  = sidx[i][pos[i]];
        e_last[i] = (pos[i] == rounds_t[i] - 1);
    endtask

    // Cycle model: accept -> two cycles of latency -> one subkey per accepted handshake.
    task automatic model_step(input int i);
        logic [127:0] k;
        k = (i == 1) ? key128 : {64'd0, key64};
        if (!Reset) begin
            ph[i] = 0; e_ready[i] = 1'b1; e_valid[i] = 1'b0; e_last[i] = 1'b0;
            e_sub[i] = '0; e_idx[i] = 0; chk_data[i] = 1'b1;
        end else if (ph[i] == 0) begin
            if (Key_valid) begin
                build(i, k, Decrypt);
                ph[i] = 1; e_ready[i] = 1'b0; chk_data[i] = 1'b0;
            end
        end else if (ph[i] == 1) begin
            ph[i] = 2;
        end else if (ph[i] == 2) begin
            ph[i] = 3; pos[i] = 0; e_valid[i] = 1'b1; chk_data[i] = 1'b1;
            present(i);
        end else if (Subkey_ready) begin
            if (pos[i] == rounds_t[i] - 1) begin
                ph[i] = 0; e_valid[i] = 1'b0; e_last[i] = 1'b0; e_ready[i] = 1'b1; chk_data[i] = 1'b0;
            end else begin
                pos[i]++;
                present(i);
            end
        end
    endtask

    always @(posedge Clk) begin
        for (int i = 0; i < NI; i++) model_step(i);
    end

    // Compare every instance against the model on the falling edge.
    always @(negedge Clk) begin
        if (run_chk) begin
            for (int i = 0; i < NI; i++) begin
                logic        a_rdy, a_val, a_last;
                logic [95:0] a_sub;
                logic [4:0]  a_idx;
                case (i)
                    0:       begin a_rdy = kr0; a_val = v0; a_last = l0; a_sub = {48'd0, sk0}; a_idx = ri0; end
                    1:       begin a_rdy = kr1; a_val = v1; a_last = l1; a_sub = sk1;          a_idx = ri1; end
                    default: begin a_rdy = kr2; a_val = v2; a_last = l2; a_sub = {48'd0, sk2}; a_idx = ri2; end
                endcase
                chk($sformatf("u%0d key_ready", i), 96'(a_rdy), 96'(e_ready[i]));
                chk($sformatf("u%0d subkey_valid", i), 96'(a_val), 96'(e_valid[i]));
                chk($sformatf("u%0d last", i), 96'(a_last), 96'(e_last[i]));
                if (chk_data[i]) begin
                    chk($sformatf("u%0d subkey", i), a_sub, e_sub[i]);
                    chk($sformatf("u%0d round_idx", i), 96'(a_idx), 96'(e_idx[i]));
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge Clk);
            #2;
        end
    endtask

    task automatic send(input logic [63:0] k, input bit dec);
        key64 = k; key128 = {k, k}; Decrypt = dec; Key_valid = 1'b1;
        step(1);
        Key_valid = 1'b0;
    endtask

    initial begin
        Reset = 1'b0; Key_valid = 1'b0; Decrypt = 1'b0; Subkey_ready = 1'b1;
        key64 = '0; key128 = '0;

        // Pin the model against known DES values.
        chk("pin_pc1", 96'(m_pc1(KEY_A)), 96'({28'hF0CCAAF, 28'h556678F}));
        build(0, {64'd0, KEY_A}, 1'b0);
        chk("pin_enc_k1", seq[0][0], 96'(K1));
        chk("pin_enc_k2", seq[0][1], 96'(K2));
        chk("pin_enc_k16", seq[0][15], 96'(K16));
        build(0, {64'd0, KEY_A}, 1'b1);
        chk("pin_dec_first", seq[0][0], 96'(K16));
        chk("pin_dec_first_idx", 96'(sidx[0][0]), 96'd16);
        chk("pin_dec_last", seq[0][15], 96'(K1));
        build(1, {KEY_A, KEY_A}, 1'b0);
        chk("pin_128_k1", seq[1][0], {K1, K1});

        step(1);
        run_chk = 1'b1;
        step(2);
        Reset = 1'b1;
        step(1);

        // Encrypt then decrypt of the reference key.
        send(KEY_A, 1'b0);
        step(22);
        send(KEY_A, 1'b1);
        step(22);

        // Backpressure around round 5.
        send(KEY_A, 1'b0);
        step(5);
        Subkey_ready = 1'b0;
        step(3);
        Subkey_ready = 1'b1;
        step(22);

        // Key offered continuously: ignored while busy, taken right after the last handshake.
        Key_valid = 1'b1;
        for (int c = 0; c < 45; c++) begin
            key64 = {$urandom, $urandom};
            key128 = {$urandom, $urandom, $urandom, $urandom};
            Decrypt = c[0];
            step(1);
        end
        Key_valid = 1'b0;
        step(22);

        // Reset mid-stream, then a clean restart.
        send(KEY_A, 1'b0);
        step(8);
        Reset = 1'b0;
        step(1);
        Reset = 1'b1;
        send(KEY_A, 1'b1);
        step(22);

        // Randomized traffic with random backpressure and occasional resets.
        for (int c = 0; c < 800; c++) begin
            Key_valid    = ($urandom_range(0, 3) == 0);
            Decrypt      = $urandom_range(0, 1) == 1;
            Subkey_ready = ($urandom_range(0, 9) < 7);
            key64        = {$urandom, $urandom};
            key128       = {$urandom, $urandom, $urandom, $urandom};
            Reset        = !($urandom_range(0, 249) == 0);
            step(1);
        end
        Reset = 1'b1; Key_valid = 1'b0; Subkey_ready = 1'b1;
        step(25);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
